// File: rtl/key_encoder_pkg.sv
// Shared constants for the debounced priority key encoder: state encoding,
// counter width and the default debounce length.
package key_encoder_pkg;

  localparam int CNT_W               = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_VALID    = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

endpackage

// File: rtl/priority_encoder8.sv
// 8-to-3 priority encoder; the highest set bit wins. The code reads 0 when no
// bit is set, and o_any flags whether the code means anything.
module priority_encoder8 (
  input  logic [7:0] i_d,
  output logic [2:0] o_code,
  output logic       o_any
);

  always_comb begin
    o_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i_d[i]) o_code = 3'(i);
    end
  end

  assign o_any = |i_d;

endmodule

// File: rtl/key_encoder.sv
// Debounced priority key encoder: a key code is reported only after it has
// been stable for DEBOUNCE_CYCLES edges, and re-arms only after a debounced release.
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e,
  input  logic [7:0] d,
  input  logic       ack,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_cap;
  logic [2:0]       r_code;
  logic             r_valid;
  logic             r_busy;

  logic [2:0]       w_code;
  logic             w_any;

  priority_encoder8 u_penc (
    .i_d    (d),
    .o_code (w_code),
    .o_any  (w_any)
  );

  // busy is registered alongside the state, so every branch that returns to
  // IDLE also drops it; the counter is cleared on every state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (e && w_any) begin
            r_cap   <= w_code;
            r_cnt   <= '0;
            r_state <= ST_DEBOUNCE;
            r_busy  <= 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (!e || !w_any || (w_code != r_cap)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_code  <= r_cap;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_VALID;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_VALID: begin
          // Disable wins over acknowledge on the same edge.
          if (!e) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (ack) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!e) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_any) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a     = r_code[2];
  assign b     = r_code[1];
  assign c     = r_code[0];
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule

// File: tb/tb_key_encoder.sv
// Self-checking bench for key_encoder: expected codes are queued as keys are
// pressed and popped by a monitor whenever valid rises.
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       reset, e, ack;
  logic [7:0] d;
  logic       a, b, c, valid, busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_code;
  logic       prev_v = 1'b0;

  key_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .e     (e),
    .d     (d),
    .ack   (ack),
    .a     (a),
    .b     (b),
    .c     (c),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: each rising valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid === 1'b1 && prev_v === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid got code=%b required no valid", {a, b, c});
      end else begin
        exp_code = exp_q.pop_front();
        if ({a, b, c} !== exp_code) begin
          errors++;
          $display("FAIL sb_code got %b required %b", {a, b, c}, exp_code);
        end
      end
    end
    prev_v <= valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_key();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    d   = 8'h00;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; e = 1'b1; d = 8'hFF; ack = 1'b1;
    tick();
    tick();
    checks++;
    if ({a, b, c, valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got abc=%b valid=%b busy=%b required all 0", {a, b, c}, valid, busy);
    end
    d = 8'h00; ack = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    d = 8'h04;
    exp_q.push_back(3'b010);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy edge=%0d got %b required 1", k, busy);
      end
      checks++;
      if (valid !== (k == 5)) begin
        errors++;
        $display("FAIL basic_latency edge=%0d got valid=%b required %b", k, valid, (k == 5));
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || {a, b, c} !== 3'b010) begin
      errors++;
      $display("FAIL basic_ack got valid=%b abc=%b required 0 010", valid, {a, b, c});
    end
    d = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (busy !== (k < 4)) begin
        errors++;
        $display("FAIL basic_release edge=%0d got busy=%b required %b", k, busy, (k < 4));
      end
    end
  endtask

  task automatic test_priority_hold();
    d = 8'h90;
    exp_q.push_back(3'b111);
    repeat (5) tick();
    checks++;
    if (valid !== 1'b1 || {a, b, c} !== 3'b111) begin
      errors++;
      $display("FAIL prio_valid got valid=%b abc=%b required 1 111", valid, {a, b, c});
    end
    d = 8'h01;
    repeat (3) tick();
    checks++;
    if (valid !== 1'b1 || {a, b, c} !== 3'b111) begin
      errors++;
      $display("FAIL prio_hold got valid=%b abc=%b required 1 111", valid, {a, b, c});
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || {a, b, c} !== 3'b111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_ack got valid=%b abc=%b busy=%b required 0 111 1", valid, {a, b, c}, busy);
    end
    d = 8'h00;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_release_early got busy=%b required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_release_done got busy=%b required 0", busy);
    end
  endtask

  task automatic test_abort();
    d = 8'h01;
    repeat (2) tick();
    d = 8'h02;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b valid=%b required 0 0", busy, valid);
    end
    exp_q.push_back(3'b001);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (valid !== (k == 5)) begin
        errors++;
        $display("FAIL abort_redebounce edge=%0d got valid=%b required %b", k, valid, (k == 5));
      end
    end
    release_key();
  endtask

  task automatic test_bounce();
    d = 8'h01;
    exp_q.push_back(3'b000);
    repeat (5) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d = (k % 2 == 0) ? 8'h00 : 8'h01;
      tick();
      checks++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL bounce_release k=%0d got busy=%b valid=%b required 1 0", k, busy, valid);
      end
    end
    d = 8'h00;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_idle got busy=%b required 0", busy);
    end
  endtask

  task automatic test_enable_ack();
    d = 8'h20;
    exp_q.push_back(3'b101);
    repeat (5) tick();
    checks++;
    if (valid !== 1'b1 || {a, b, c} !== 3'b101) begin
      errors++;
      $display("FAIL en_valid got valid=%b abc=%b required 1 101", valid, {a, b, c});
    end
    e = 1'b0; ack = 1'b1; d = 8'h00;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_over_ack got valid=%b busy=%b required 0 0", valid, busy);
    end
    d = 8'h04;
    repeat (6) tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_gated got valid=%b busy=%b required 0 0", valid, busy);
    end
    d = 8'h00;
    e = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    d = 8'h08;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({a, b, c, valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid got abc=%b valid=%b busy=%b required all 0", {a, b, c}, valid, busy);
    end
    tick();
    reset = 1'b0;
    exp_q.push_back(3'b011);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (valid !== (k == 5)) begin
        errors++;
        $display("FAIL rst_fresh edge=%0d got valid=%b required %b", k, valid, (k == 5));
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d = 8'h00;
    checks++;
    if ({a, b, c, valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rst_valid got abc=%b valid=%b busy=%b required all 0", {a, b, c}, valid, busy);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    d = 8'h40;
    exp_q.push_back(3'b110);
    repeat (5) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_held k=%0d got valid=%b busy=%b required 0 1", k, valid, busy);
      end
    end
    d = 8'h00;
    repeat (4) tick();
    d = 8'h80;
    exp_q.push_back(3'b111);
    repeat (5) tick();
    checks++;
    if (valid !== 1'b1 || {a, b, c} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_second got valid=%b abc=%b required 1 111", valid, {a, b, c});
    end
    release_key();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority_hold();
    test_abort();
    test_bounce();
    test_enable_ack();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_missing got %0d codes outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
